sync_filter_bank: RTL and testbench
===================================

SYNC_FILTER_BANK -- requirements
Module: sync_filter_bank

Interface
REQ-001 Parameter WIDTH, default 1: number of independent input channels (1..32).
REQ-002 Parameter STAGES, default 2: synchronizer flop depth per channel (2..4).
REQ-003 Parameter RST_VAL, default 1'b0: reset level of every synchronizer stage, filter output and edge-history flop.
REQ-004 Parameter FILT_CNT, default 4: consecutive stable cycles required before the filtered output changes (1..255).
REQ-005 clk  input  1  sole clock; all flops on rising edge.
REQ-006 n_rst  input  1  reset, synchronous and active-low.
REQ-007 async_in  input  WIDTH  asynchronous channel inputs.
REQ-008 sync_out  output  WIDTH  synchronized level, last synchronizer stage.
REQ-009 filt_out  output  WIDTH  glitch-filtered level.
REQ-010 rise  output  WIDTH  one-cycle pulse on filt_out 0->1.
REQ-011 fall  output  WIDTH  one-cycle pulse on filt_out 1->0.

Function
REQ-012 Each channel SHALL pass async_in through a STAGES-deep flop chain; a level present at edge t SHALL appear on sync_out after edge t+STAGES-1.
REQ-013 Channels SHALL be fully independent; no cross-channel logic.
REQ-014 Per channel, a counter SHALL clear whenever sync_out equals filt_out and increment each cycle they differ.
REQ-015 When the counter is FILT_CNT-1 and sync_out still differs, filt_out SHALL take sync_out at that edge and the counter SHALL clear.
REQ-016 Any return of sync_out to filt_out before the count completes SHALL clear the counter with filt_out unchanged (glitch rejected).
REQ-017 FILT_CNT=1 SHALL make filt_out follow sync_out with one cycle delay.
REQ-018 Counter width SHALL be $clog2(FILT_CNT+1) bits; it SHALL never exceed FILT_CNT-1 (no wrap).
REQ-019 rise SHALL be high exactly in the first cycle filt_out is 1 after being 0; fall likewise for 1->0; never both.
REQ-020 rise/fall SHALL be derived from filt_out and a one-flop history register, with no further latency.

Reset
REQ-021 While n_rst=0 at a clock edge, all synchronizer stages, filt_out and history flops SHALL load RST_VAL and all counters SHALL load 0.
REQ-022 sync_out and filt_out SHALL equal RST_VAL and rise/fall SHALL be 0 from the first edge with n_rst=0.
REQ-023 Reset asserted mid-filter-count SHALL abort the count with no output change other than to RST_VAL and no rise/fall pulse.
REQ-024 Reset is not observed without a clock edge.

Configuration
REQ-025 Macro SYNC_FILTER_EN defined: counters per REQ-014..018 are compiled in.
REQ-026 Macro SYNC_FILTER_EN undefined: no counters; filt_out SHALL be a combinational copy of sync_out; rise/fall then track sync_out edges; FILT_CNT ignored.

Structure
REQ-027 Package sync_pkg SHALL hold parameter range limits (STAGES_MIN=2, STAGES_MAX=4, FILT_CNT_MAX=255) and a function returning the counter width.
REQ-028 One sub-module, sync_filter_chan, SHALL implement a single channel (chain, counter, history), instantiated WIDTH times by generate.
REQ-029 Out-of-range parameters SHALL trigger an elaboration-time error.

Verification
REQ-030 Reset: n_rst=0 for 2 edges, RST_VAL=0, async_in='1 -> sync_out=0, filt_out=0, rise=fall=0.
REQ-031 Latency: STAGES=3, async_in 0->1 before edge 10 -> sync_out=1 after edge 12; filt_out=1 after edge 16 (FILT_CNT=4); rise=1 for that cycle only.
REQ-032 Glitch: FILT_CNT=4, sync_out high for 3 cycles then low -> filt_out stays 0, no rise.
REQ-033 Channels: WIDTH=8, toggle only bit 5 -> only filt_out[5], rise[5] change.
REQ-034 Mid-count reset: n_rst=0 with counter at 2 -> filt_out=RST_VAL, counter 0, no pulse; after release, full FILT_CNT required again.
REQ-035 Without SYNC_FILTER_EN: one-cycle sync_out pulse -> filt_out mirrors it, rise and fall each pulse once.

Source files
------------

// File: rtl/sync_pkg.sv
// sync_pkg: parameter limits and counter sizing shared by the synchronizer filter bank.
package sync_pkg;
    localparam int WIDTH_MAX    = 32;
    localparam int STAGES_MIN   = 2;
    localparam int STAGES_MAX   = 4;
    localparam int FILT_CNT_MAX = 255;

    function automatic int cnt_width(input int filt_cnt);
        return $clog2(filt_cnt + 1);
    endfunction
endpackage

// File: rtl/sync_filter_bank_if.sv
// sync_filter_bank_if: channel inputs and synchronized/filtered outputs of the filter bank.
interface sync_filter_bank_if #(parameter int WIDTH = 1);
    logic [WIDTH-1:0] async_in;
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] filt_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    modport master (output async_in, input sync_out, filt_out, rise, fall);
    modport slave (input async_in, output sync_out, filt_out, rise, fall);
endinterface

// File: rtl/sync_filter_chan.sv
// sync_filter_chan: one channel -- flop synchronizer, optional glitch filter, edge detect.
// Glitch filter compiled in only when SYNC_FILTER_EN is defined.
module sync_filter_chan
    import sync_pkg::*;
#(
    parameter int   STAGES   = 2,
    parameter logic RST_VAL  = 1'b0,
    parameter int   FILT_CNT = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic async_in,
    output logic sync_out,
    output logic filt_out,
    output logic rise,
    output logic fall
);
    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("sync_filter_chan: STAGES out of range");
    end
    if (FILT_CNT < 1 || FILT_CNT > FILT_CNT_MAX) begin : g_bad_filt_cnt
        $error("sync_filter_chan: FILT_CNT out of range");
    end

    logic [STAGES-1:0] chain;
    logic              hist;

    always_ff @(posedge clk)
        chain <= !n_rst ? {STAGES{RST_VAL}} : {chain[STAGES-2:0], async_in};

    assign sync_out = chain[STAGES-1];

`ifdef SYNC_FILTER_EN
    localparam int CW = cnt_width(FILT_CNT);
    logic [CW-1:0] cnt;
    logic          filt_q;

    // Count cycles of disagreement; adopt the new level only after FILT_CNT in a row.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt    <= '0;
            filt_q <= RST_VAL;
        end else if (sync_out == filt_q) begin
            cnt <= '0;
        end else if (cnt == CW'(FILT_CNT - 1)) begin
            cnt    <= '0;
            filt_q <= sync_out;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign filt_out = filt_q;
`else
    assign filt_out = sync_out;
`endif

    always_ff @(posedge clk)
        hist <= !n_rst ? RST_VAL : filt_out;

    assign rise = filt_out & ~hist;
    assign fall = ~filt_out & hist;
endmodule

// File: rtl/sync_filter_bank.sv
// sync_filter_bank: WIDTH independent synchronizer/glitch-filter/edge-detect channels.
// Filtering enabled by SYNC_FILTER_EN; otherwise filt_out mirrors sync_out.
module sync_filter_bank
    import sync_pkg::*;
#(
    parameter int   WIDTH    = 1,
    parameter int   STAGES   = 2,
    parameter logic RST_VAL  = 1'b0,
    parameter int   FILT_CNT = 4
) (
    input logic                clk,
    input logic                n_rst,
    sync_filter_bank_if.slave  bus
);
    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("sync_filter_bank: WIDTH out of range");
    end

    for (genvar c = 0; c < WIDTH; c++) begin : g_chan
        sync_filter_chan #(
            .STAGES  (STAGES),
            .RST_VAL (RST_VAL),
            .FILT_CNT(FILT_CNT)
        ) u_chan (
            .clk     (clk),
            .n_rst   (n_rst),
            .async_in(bus.async_in[c]),
            .sync_out(bus.sync_out[c]),
            .filt_out(bus.filt_out[c]),
            .rise    (bus.rise[c]),
            .fall    (bus.fall[c])
        );
    end
endmodule

// File: tb/tb_sync_filter_bank.sv
// tb_sync_filter_bank: randomized + directed stimulus with a scoreboard against a
// delay-line / run-length reference model of the filter bank.
module tb_sync_filter_bank;
    localparam int   W        = 8;
    localparam int   STAGES   = 3;
    localparam int   FILT_CNT = 4;
    localparam logic RST      = 1'b0;

    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] f;
        logic [W-1:0] r;
        logic [W-1:0] fl;
    } exp_t;

    logic clk = 0;
    logic n_rst = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    logic [W-1:0] dl[$];
    logic [W-1:0] filt;
    int           run[W];

    sync_filter_bank_if #(.WIDTH(W)) bus();

    sync_filter_bank #(
        .WIDTH   (W),
        .STAGES  (STAGES),
        .RST_VAL (RST),
        .FILT_CNT(FILT_CNT)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference: sync_out is the input sampled STAGES-1 edges earlier; filt_out adopts
    // sync_out once they have disagreed for FILT_CNT consecutive edges.
    task automatic model(input logic [W-1:0] a, input logic rn);
        exp_t         e;
        logic [W-1:0] f_prev;
`ifdef SYNC_FILTER_EN
        logic [W-1:0] s_pre;
`endif
        if (!rn) begin
            dl.delete();
            repeat (STAGES) dl.push_back({W{RST}});
            filt   = {W{RST}};
            f_prev = {W{RST}};
            for (int i = 0; i < W; i++) run[i] = 0;
        end else begin
            f_prev = filt;
`ifdef SYNC_FILTER_EN
            s_pre = dl[0];
`endif
            dl.push_back(a);
            void'(dl.pop_front());
`ifdef SYNC_FILTER_EN
            for (int i = 0; i < W; i++) begin
                if (s_pre[i] !== filt[i]) begin
                    run[i]++;
                    if (run[i] == FILT_CNT) begin
                        filt[i] = s_pre[i];
                        run[i]  = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
`else
            filt = dl[0];
`endif
        end
        e.s  = dl[0];
        e.f  = filt;
        e.r  = filt & ~f_prev;
        e.fl = ~filt & f_prev;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [W-1:0] a, input logic rn);
        bus.async_in = a;
        n_rst        = rn;
        @(posedge clk);
        model(a, rn);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sync_out", bus.sync_out, e.s);
            chk("filt_out", bus.filt_out, e.f);
            chk("rise", bus.rise, e.r);
            chk("fall", bus.fall, e.fl);
            chk("rise_and_fall", bus.rise & bus.fall, '0);
        end
    end

    initial begin
        logic [W-1:0] cur;
        bus.async_in = '1;
        // reset with inputs all high, then settle low
        repeat (2) step('1, 1'b0);
        repeat (8) step('0, 1'b1);
        // latency: single channel step
        repeat (10) step(8'h01, 1'b1);
        repeat (10) step(8'h00, 1'b1);
        // glitch of 3 cycles (rejected) and 4 cycles (accepted)
        repeat (3) step(8'h02, 1'b1);
        repeat (10) step(8'h00, 1'b1);
        repeat (4) step(8'h02, 1'b1);
        repeat (10) step(8'h00, 1'b1);
        // channel isolation on bit 5
        repeat (10) step(8'h20, 1'b1);
        repeat (10) step(8'h00, 1'b1);
        // reset in the middle of a count, then full count required again
        repeat (STAGES - 1 + 2) step('1, 1'b1);
        step('1, 1'b0);
        repeat (12) step('1, 1'b1);
        repeat (10) step('0, 1'b1);
        // randomized: sparse per-bit toggles and occasional resets
        cur = '0;
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 5) == 0) cur[i] = ~cur[i];
            step(cur, $urandom_range(0, 59) != 0);
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
